can_rx_sequencer: RTL

//  Receive-side frame sequencer; sits between the bit sampler and candecoder/crc_checker.
//  Per sampled bit: tracks the current CAN field, removes stuff bits and detects stuff errors.

---
 rtl/can_rx_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/can_rx_sequencer.sv
// can_rx_sequencer: CAN receive field tracker, bit destuffer and CRC sequencer.
// Optional fixed-form bit checking is enabled by defining CAN_RX_SEQ_FORM_CHECK_EN.
module can_rx_sequencer #(
  parameter int IDLE_BITS = 11,
  parameter int MAX_BYTES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       rx_bit,
  output logic       dbit_valid,
  output logic       dbit,
  output logic       crc_clear,
  output logic       crc_en,
  output logic [3:0] field,
  output logic       ide,
  output logic       rtr,
  output logic [3:0] dlc,
  output logic       stuff_error,
  output logic       form_error,
  output logic       frame_done,
  output logic       busy
);
  localparam int CW = $clog2(IDLE_BITS + 1);

  typedef enum logic [3:0] {
    F_IDLE, F_SOF, F_ID_A, F_SRR_RTR, F_IDE, F_ID_B, F_RTR_X, F_RSV,
    F_DLC, F_DATA, F_CRC, F_CRC_DEL, F_ACK, F_ACK_DEL, F_EOF, F_ERROR
  } field_t;

  field_t        cur;
  field_t        nxt;
  logic [CW-1:0] idle_cnt;
  logic [6:0]    bit_cnt;
  logic [6:0]    nxt_cnt;
  logic          last_val;
  logic [2:0]    run;
  logic [2:0]    run_nx;
  logic [3:0]    dlc_nx;
  logic [3:0]    nbytes;
  logic [6:0]    data_len;
  logic          stuffed;
  logic          stuff_bit;
  logic          stuff_viol;
  logic          last_bit;
  logic          form_bad;
  logic          err;

  assign stuffed    = (cur >= F_ID_A) && (cur <= F_CRC);
  assign stuff_bit  = stuffed && (run == 3'd5);
  assign stuff_viol = stuff_bit && (rx_bit == last_val);
  assign last_bit   = (bit_cnt == 7'd1);
  assign run_nx     = (rx_bit == last_val) ? run + 3'd1 : 3'd1;
  assign dlc_nx     = {dlc[2:0], rx_bit};
  assign nbytes     = (dlc_nx > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc_nx;
  assign data_len   = {nbytes, 3'b000};

`ifdef CAN_RX_SEQ_FORM_CHECK_EN
  // rtr still holds bit 3 while IDE arrives; for extended frames that is SRR
  assign form_bad = (!rx_bit && (cur == F_CRC_DEL || cur == F_ACK_DEL || cur == F_EOF))
                 || (cur == F_IDE && rx_bit && !rtr);
`else
  assign form_bad = 1'b0;
`endif

  assign err = stuff_viol || (form_bad && !stuff_bit);

  always_comb begin
    nxt     = cur;
    nxt_cnt = bit_cnt - 7'd1;
    if (last_bit) begin
      unique case (cur)
        F_ID_A:    begin nxt = F_SRR_RTR; nxt_cnt = 7'd1; end
        F_SRR_RTR: begin nxt = F_IDE; nxt_cnt = 7'd1; end
        F_IDE: begin
          nxt     = rx_bit ? F_ID_B : F_RSV;
          nxt_cnt = rx_bit ? 7'd18 : 7'd1;
        end
        F_ID_B:    begin nxt = F_RTR_X; nxt_cnt = 7'd1; end
        F_RTR_X:   begin nxt = F_RSV; nxt_cnt = 7'd2; end
        F_RSV:     begin nxt = F_DLC; nxt_cnt = 7'd4; end
        F_DLC: begin
          if (rtr || data_len == 7'd0) begin
            nxt = F_CRC; nxt_cnt = 7'd15;
          end else begin
            nxt = F_DATA; nxt_cnt = data_len;
          end
        end
        F_DATA:    begin nxt = F_CRC; nxt_cnt = 7'd15; end
        F_CRC: begin
          // a pending stuff bit after the last CRC bit is consumed in CRC
          if (run_nx == 3'd5) begin
            nxt = F_CRC; nxt_cnt = 7'd0;
          end else begin
            nxt = F_CRC_DEL; nxt_cnt = 7'd1;
          end
        end
        F_CRC_DEL: begin nxt = F_ACK; nxt_cnt = 7'd1; end
        F_ACK:     begin nxt = F_ACK_DEL; nxt_cnt = 7'd1; end
        F_ACK_DEL: begin nxt = F_EOF; nxt_cnt = 7'd7; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur         <= F_IDLE;
      idle_cnt    <= '0;
      bit_cnt     <= '0;
      last_val    <= 1'b0;
      run         <= '0;
      dbit_valid  <= 1'b0;
      dbit        <= 1'b0;
      crc_clear   <= 1'b0;
      crc_en      <= 1'b0;
      field       <= 4'd0;
      ide         <= 1'b0;
      rtr         <= 1'b0;
      dlc         <= 4'd0;
      stuff_error <= 1'b0;
      form_error  <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dbit_valid  <= 1'b0;
      crc_clear   <= 1'b0;
      crc_en      <= 1'b0;
      stuff_error <= 1'b0;
      form_error  <= 1'b0;
      frame_done  <= 1'b0;
      if (sample_en) begin
        dbit  <= rx_bit;
        field <= cur;
        if (cur == F_IDLE) begin
          if (rx_bit) begin
            if (idle_cnt != CW'(IDLE_BITS)) idle_cnt <= idle_cnt + CW'(1);
          end else if (idle_cnt == CW'(IDLE_BITS)) begin
            cur        <= F_ID_A;
            bit_cnt    <= 7'd11;
            field      <= F_SOF;
            last_val   <= 1'b0;
            run        <= 3'd1;
            idle_cnt   <= '0;
            crc_clear  <= 1'b1;
            crc_en     <= 1'b1;
            dbit_valid <= 1'b1;
            busy       <= 1'b1;
            ide        <= 1'b0;
            rtr        <= 1'b0;
            dlc        <= 4'd0;
          end else begin
            idle_cnt <= '0;
          end
        end else if (err) begin
          cur         <= F_IDLE;
          idle_cnt    <= '0;
          field       <= F_ERROR;
          busy        <= 1'b0;
          stuff_error <= stuff_viol;
          form_error  <= !stuff_viol;
        end else if (stuff_bit) begin
          last_val <= rx_bit;
          run      <= 3'd1;
          if (cur == F_CRC && bit_cnt == 7'd0) begin
            cur     <= F_CRC_DEL;
            bit_cnt <= 7'd1;
          end
        end else begin
          dbit_valid <= 1'b1;
          crc_en     <= (cur <= F_DATA);
          if (stuffed) begin
            last_val <= rx_bit;
            run      <= run_nx;
          end
          unique case (cur)
            F_SRR_RTR: rtr <= rx_bit;
            F_IDE:     ide <= rx_bit;
            F_RTR_X:   rtr <= rx_bit;
            F_DLC:     dlc <= dlc_nx;
            default: ;
          endcase
          if (cur == F_EOF && last_bit) begin
            cur        <= F_IDLE;
            idle_cnt   <= CW'(7);
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cur     <= nxt;
            bit_cnt <= nxt_cnt;
          end
        end
      end
    end
  end
endmodule
